// File: rtl/tcdm_resp_pkg.sv
// Shared types and defaults for the TCDM memory responder: the response
// pipeline stage record and the default window/error constants.
package tcdm_resp_pkg;

    typedef struct packed {
        logic valid;
        logic err;
        logic is_read;
    } resp_stage_t;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_MEM_ADDR_WIDTH = 12;
    localparam int BE_WIDTH               = DEFAULT_DATA_WIDTH / 8;
    localparam int WIN_BYTES              = 4 * (2 ** DEFAULT_MEM_ADDR_WIDTH);

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADA_CCE5;

    // Byte size of a window of 2^mem_addr_width 32-bit words.
    function automatic int win_bytes(input int mem_addr_width);
        return 4 * (2 ** mem_addr_width);
    endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Fixed-latency response pipeline: LATENCY stages of {valid, err, is_read}
// plus the read-data delay line fed from the SRAM one cycle after grant.
module tcdm_resp_pipe
    import tcdm_resp_pkg::*;
#(
    parameter int                    LATENCY    = 1,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  resp_stage_t           i_stage,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_opc
);

    resp_stage_t           r_stage [LATENCY];
    resp_stage_t           w_last;
    logic [DATA_WIDTH-1:0] w_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= i_stage;
            for (int k = 1; k < LATENCY; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // SRAM data is valid alongside stage 0; deeper pipes delay it to match.
    generate
        if (LATENCY == 1) begin : g_direct
            assign w_data = i_mem_rdata;
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] r_dly [1:LATENCY-1];

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int k = 1; k < LATENCY; k++) begin
                        r_dly[k] <= '0;
                    end
                end else begin
                    r_dly[1] <= i_mem_rdata;
                    for (int k = 2; k < LATENCY; k++) begin
                        r_dly[k] <= r_dly[k-1];
                    end
                end
            end

            assign w_data = r_dly[LATENCY-1];
        end
    endgenerate

    assign w_last = r_stage[LATENCY-1];

    always_comb begin
        o_valid = w_last.valid;
        o_opc   = w_last.valid & w_last.err;
        o_rdata = '0;
        if (w_last.valid && w_last.is_read) begin
            o_rdata = w_last.err ? ERR_DATA : w_data;
        end
    end

endmodule

// File: rtl/tcdm_mem_responder.sv
// TCDM slave: decodes the address window, applies wait states and stall,
// grants, drives a UNICAD-style single-port SRAM and returns in-order responses.
module tcdm_mem_responder
    import tcdm_resp_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MEM_ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1C00_0000,
    parameter int                    LATENCY        = 1,
    parameter int                    WAIT_STATES    = 0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [ADDR_WIDTH-1:0]     add_i,
    input  logic                      wen_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [DATA_WIDTH-1:0]     r_rdata_o,
    output logic                      r_opc_o,
    input  logic                      stall_i,
    output logic                      mem_csn_o,
    output logic                      mem_wen_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_add_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    // One extra bit so BASE + window size cannot wrap at the top of the map.
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT =
        BASE_EXT + (ADDR_WIDTH+1)'(win_bytes(MEM_ADDR_WIDTH));
    localparam logic [2:0]          WS_MAX    = 3'(WAIT_STATES);

    logic [2:0]            r_wcnt;
    logic [ADDR_WIDTH:0]   w_addExt;
    logic [ADDR_WIDTH-1:0] w_diff;
    logic                  w_inRange;
    logic                  w_gnt;
    logic                  w_access;
    resp_stage_t           w_stage;

    assign w_addExt  = {1'b0, add_i};
    assign w_inRange = (w_addExt >= BASE_EXT) && (w_addExt < LIMIT_EXT);
    assign w_diff    = add_i - BASE_ADDR;

    assign w_gnt    = req_i & ~stall_i & (r_wcnt == WS_MAX) & ~rst_i;
    assign w_access = w_gnt & w_inRange;
    assign gnt_o    = w_gnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wcnt <= '0;
        end else if (!req_i || w_gnt) begin
            r_wcnt <= '0;
        end else if (r_wcnt < WS_MAX) begin
            r_wcnt <= r_wcnt + 3'd1;
        end
    end

    // SRAM bus is driven only for granted in-range requests; idle otherwise.
    assign mem_csn_o   = ~w_access;
    assign mem_wen_o   = w_access ? wen_i : 1'b1;
    assign mem_add_o   = w_access ? MEM_ADDR_WIDTH'(w_diff >> 2) : '0;
    assign mem_wdata_o = w_access ? wdata_i : '0;
    assign mem_be_o    = w_access ? be_i : '0;

    assign w_stage.valid   = w_gnt;
    assign w_stage.err     = ~w_inRange;
    assign w_stage.is_read = wen_i;

    tcdm_resp_pipe #(
        .LATENCY    (LATENCY),
        .DATA_WIDTH (DATA_WIDTH),
        .ERR_DATA   (ERR_DATA)
    ) u_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_stage     (w_stage),
        .i_mem_rdata (mem_rdata_i),
        .o_valid     (r_valid_o),
        .o_rdata     (r_rdata_o),
        .o_opc       (r_opc_o)
    );

endmodule

// File: doc/tcdm_mem_responder.md
Name: tcdm_mem_responder

Overview:
- TCDM-bus slave (responder) for the req/gnt/r_valid protocol that the fabric-controller core issues on its L2/SCM data and instruction ports.
- Decodes and grants requests, then drives a synchronous single-port SRAM macro through a UNICAD-style interface (active-low chip select and write enable).
- Returns read data or write acknowledgements in order, with fixed latency.
- Flags out-of-range accesses with an error response; the SRAM is not touched for those.

Parameters:
- ADDR_WIDTH, 32, byte address width of the TCDM port.
- DATA_WIDTH, 32, data width (BE width = DATA_WIDTH/8).
- MEM_ADDR_WIDTH, 12, SRAM word-address width; window size = 2^MEM_ADDR_WIDTH words.
- BASE_ADDR, 32'h1C00_0000, byte base of the window; must be word-aligned.
- LATENCY, 1, cycles from grant to r_valid; legal 1..3.
- WAIT_STATES, 0, cycles a request must be held before gnt; legal 0..7.
- ERR_DATA, 32'hBADA_CCE5, r_rdata returned on an error read.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  async reset, active high
- req_i  in  1  TCDM request
- add_i  in  ADDR_WIDTH  byte address
- wen_i  in  1  1 = read, 0 = write
- wdata_i  in  DATA_WIDTH  write data
- be_i  in  DATA_WIDTH/8  byte enables
- gnt_o  out  1  grant
- r_valid_o  out  1  response valid
- r_rdata_o  out  DATA_WIDTH  response data
- r_opc_o  out  1  1 = error response
- stall_i  in  1  external bank-busy; suppresses gnt
- mem_csn_o  out  1  SRAM chip select, active low
- mem_wen_o  out  1  SRAM write enable, active low
- mem_add_o  out  MEM_ADDR_WIDTH  SRAM word address
- mem_wdata_o  out  DATA_WIDTH  SRAM write data
- mem_be_o  out  DATA_WIDTH/8  SRAM byte enables
- mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after a read access

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-high.
- Reset values: r_valid_o=0, r_rdata_o=0, r_opc_o=0, wait counter=0, all pipeline valids=0. While rst_i=1: gnt_o=0 and mem_csn_o=1.
- Decode: in_range = (add_i >= BASE_ADDR) && (add_i < BASE_ADDR + 4*2^MEM_ADDR_WIDTH). Comparison is done in ADDR_WIDTH+1 bits so the upper bound cannot overflow.
- Word offset: (add_i - BASE_ADDR) >> 2. add_i[1:0] is ignored; byte selection comes from be_i only.
- Wait counter (wcnt, 3 bits):
  - cleared when req_i=0 or gnt_o=1;
  - otherwise increments while req_i=1 and wcnt<WAIT_STATES;
  - holds at WAIT_STATES.
- Grant: gnt_o = req_i & ~stall_i & (wcnt==WAIT_STATES). It is combinational, so same-cycle grant when WAIT_STATES=0. stall_i held high means no grant; req_i is held and wcnt saturates.
- SRAM access on a granted in-range request, in the grant cycle:
  - mem_csn_o=0;
  - mem_wen_o=wen_i;
  - mem_add_o=offset;
  - mem_wdata_o=wdata_i;
  - mem_be_o=be_i.
  Otherwise mem_csn_o=1. Granted out-of-range requests never assert mem_csn_o.
- Response pipeline: LATENCY stages, each holding {valid, err, is_read}. Stage 0 is loaded at the grant clock edge.
  - Read data is captured from mem_rdata_i at the stage-0 output (SRAM latency 1). It then advances through LATENCY-1 further data registers.
  - r_valid_o is asserted exactly LATENCY cycles after the grant cycle, for one cycle per granted request. This holds for reads and writes.
  - Write response: r_rdata_o=0, r_opc_o=0.
  - In-range read: r_rdata_o = SRAM word; r_opc_o=0.
  - Out-of-range read: r_rdata_o=ERR_DATA, r_opc_o=1.
  - Out-of-range write: r_rdata_o=0, r_opc_o=1.
- Throughput: back-to-back grants give back-to-back responses in order. There is no response backpressure.
- Simultaneous events: a new grant and a response retiring in the same cycle are independent. stall_i does not affect in-flight responses.
- Reset mid-operation: all in-flight responses are discarded, with no r_valid after reset release. The SRAM contents are untouched.

Decomposition:
- Package tcdm_resp_pkg:
  - resp_stage_t struct {valid, err, is_read};
  - localparams BE_WIDTH and WIN_BYTES;
  - default ERR_DATA constant.
- One sub-module, tcdm_resp_pipe: the parameterised LATENCY-deep shift register of resp_stage_t plus data. The top module holds decode, wait counter, grant and the SRAM drive.

Test Plan:
- Reset, then write 0xDEADBEEF to BASE+0x10 with be=4'hF, then read BASE+0x10 (LATENCY=1, WAIT_STATES=0) -> both gnt in their request cycle; mem_add_o=4; write r_valid 1 cycle later with rdata=0, opc=0; read r_valid 1 cycle after its grant with rdata=0xDEADBEEF.
- Byte write be=4'b0010 data 0x0000AA00 over 0x11223344, then read -> 0x1122AA44.
- Read BASE+0x4000 with MEM_ADDR_WIDTH=12 -> gnt, mem_csn_o stays 1, r_valid with rdata=0xBADACCE5, opc=1.
- WAIT_STATES=2, stall_i=1 for 3 cycles then 0, req held -> gnt first asserted on the cycle stall_i drops (counter already saturated); response LATENCY cycles later.
- LATENCY=3, four back-to-back reads of words 0..3 preloaded with 0xA0..0xA3 -> r_valid high 4 consecutive cycles starting 3 cycles after the first grant, data in order.
- Assert rst_i one cycle after two reads are granted at LATENCY=3 -> no r_valid after release; r_rdata_o=0 and r_opc_o=0 during reset.
